tpumac_row: RTL and testbench
=============================

Name: tpumac_row

Overview:
- Parametrised successor to the single-PE MAC: one systolic row of N output-stationary MAC processing elements (PEs).
- Operand A enters at the west edge and ripples east, one PE per cycle. Each PE takes its own B column from the north and forwards it south to the next row.
- Accumulators form a shift chain for bulk preload (LOAD) and readout (DRAIN), so a tile controller can tile rows into an array without per-PE C ports.
- Adds valid tagging, a global stall, signed saturation with a sticky overflow flag, and a load/drain state machine.

Parameters:
- N, 4: number of PEs in the row (>=2).
- BITS_AB, 8: signed operand width.
- BITS_C, 16: signed accumulator width (>= 2*BITS_AB).
- SATURATE, 1: 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global advance; 0 freezes every register
- a_in  in  BITS_AB  signed A operand, west edge
- a_valid_in  in  1  a_in qualifier
- a_out  out  BITS_AB  A leaving PE N-1, east edge
- a_valid_out  out  1  a_out qualifier
- b_in  in  N*BITS_AB  B operand for PE j in slice j
- b_valid_in  in  N  per-column B qualifier
- b_out  out  N*BITS_AB  registered b_in, to the row below
- b_valid_out  out  N  registered b_valid_in
- clr  in  1  restart accumulation
- load_start  in  1  request LOAD
- c_in  in  BITS_C  preload word, one per advancing LOAD cycle
- drain_start  in  1  request DRAIN
- c_out  out  BITS_C  drained accumulator word
- c_out_valid  out  1  c_out qualifier
- drain_done  out  1  one-cycle pulse on the last drain word
- busy  out  1  high in LOAD or DRAIN
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset: clk and reset rst_n, asynchronous, active-low. On reset all accumulators, a/b pipeline registers and their valids, c_out, c_out_valid, drain_done and ovf go to 0, and the state goes to IDLE. Reset mid-LOAD or mid-DRAIN aborts the operation immediately.
- Stall: with en=0 nothing changes, including the state, the counter, c_out and drain_done.
- Operand pipeline (all states):
  - PE j sees A delayed by j cycles (a_pe[0] = a_in combinationally; a_pe[j] = registered a_pe[j-1]).
  - a_out is registered from PE N-1, so A has N cycles of latency west to east.
  - b_out/b_valid_out are b_in/b_valid_in delayed 1 cycle.
- MAC (IDLE only): PE j fires when en, a_valid at PE j, and b_valid_in[j] are all high.
  - Product: full signed 2*BITS_AB bits, sign-extended to BITS_C+1 bits.
  - Sum: acc + product at BITS_C+1 bits.
  - Overflow (the top two bits differ) sets ovf. It clamps to +/-(2^(BITS_C-1)) (max 2^(BITS_C-1)-1) when SATURATE=1; otherwise the sum is truncated.
- clr (IDLE only):
  - Every PE's accumulator becomes 0, or becomes its product if that PE fires in the same cycle.
  - ovf clears unless an overflow occurs in the same cycle.
  - clr is ignored in LOAD and DRAIN.
- FSM: IDLE, LOAD, DRAIN; a counter runs 0..N-1.
  - IDLE -> DRAIN on drain_start. drain_start wins over a simultaneous load_start.
  - IDLE -> LOAD on load_start.
  - Starts requested while busy are ignored.
  - A start cycle performs no MAC and no shift; busy rises the next cycle.
- LOAD: on each advancing cycle, acc[0] <= c_in and acc[j] <= acc[j-1]. After N words, state returns to IDLE. The first word lands in PE N-1 and the last word in PE 0.
- DRAIN:
  - On each advancing cycle, c_out <= acc[N-1], acc[j] <= acc[j-1], and acc[0] <= 0.
  - c_out_valid is high for exactly N advancing cycles, starting the cycle after the start is accepted. Output order is PE N-1 first.
  - drain_done is high with the Nth word, then the state goes to IDLE.
  - After DRAIN all accumulators are 0.
  - A LOAD then DRAIN returns words in load order.
- c_out holds its last value when not draining; c_out_valid is 0 outside DRAIN.

Decomposition:
- Package tpu_pkg:
  - typedef state_e {IDLE, LOAD, DRAIN}.
  - Helper function sat_add(acc, prod, SATURATE) returning {ovf, result}.
- One sub-module, tpumac_pe: A/valid register, B/valid register, accumulator register with mac/clr/shift controls and ovf output.
- tpumac_row: generate loop over N tpumac_pe instances, plus the FSM, counter and drain output register.

Test Plan (N=4, BITS_AB=8, BITS_C=16 unless noted):
1. Reset with random inputs -> all outputs 0, busy=0. Assert rst_n low mid-DRAIN -> c_out_valid=0 and busy=0 without waiting for a clock edge; a subsequent drain returns 0,0,0,0.
2. clr + a_in=3 valid at t0, b_valid only on col0 with b=-5 at t0 and on col1 with b=2 at t1 -> drain yields 0,0,6,-15; a_out=3 with a_valid_out=1 at t0+4.
3. Load 10,20,30,40, then drain -> c_out 10,20,30,40 on 4 consecutive cycles; drain_done only with 40; then a second drain yields zeros.
4. Saturation: load 0,0,0,32760; a=127, b0=127 -> PE0 gives 32767 and ovf=1. With SATURATE=0 -> -16647 and ovf=1. A following clr clears ovf.
5. Stall: en=0 for 2 cycles after the second drain word -> c_out holds 20, busy holds, and 4 valid words are still delivered. Also a_out, b_out and acc stay frozen with valid inputs present.
6. load_start and drain_start in the same cycle -> DRAIN is taken. A load_start during DRAIN is ignored, and a MAC request during LOAD changes no accumulator.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and saturating add for the systolic MAC row
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SAT_W = 64;

  // Operands arrive sign-extended to SAT_W; the result is {overflow, value}.
  // With wrap the caller keeps only the low bits_c bits, which is the truncated sum.
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] prod,
    input int                      bits_c,
    input bit                      saturate
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    logic                    o;
    logic signed [SAT_W-1:0] r;
    sum  = acc + prod;
    maxv = (64'sd1 <<< (bits_c - 1)) - 64'sd1;
    minv = -maxv - 64'sd1;
    o    = 1'b0;
    r    = sum;
    if (sum > maxv) begin
      o = 1'b1;
      if (saturate) r = maxv;
    end else if (sum < minv) begin
      o = 1'b1;
      if (saturate) r = minv;
    end
    return {o, r};
  endfunction

endpackage

// File: rtl/tpumac_pe.sv
// rtl/tpumac_pe.sv - one output-stationary MAC processing element with shift-chain accumulator
import tpu_pkg::*;

module tpumac_pe #(
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BITS_AB-1:0] a,
  input  logic               a_valid,
  input  logic [BITS_AB-1:0] b,
  input  logic               b_valid,
  input  logic               mac_en,
  input  logic               clr,
  input  logic               shift,
  input  logic [BITS_C-1:0]  shift_in,
  output logic [BITS_AB-1:0] a_reg,
  output logic               a_valid_reg,
  output logic [BITS_AB-1:0] b_reg,
  output logic               b_valid_reg,
  output logic [BITS_C-1:0]  acc,
  output logic               ovf_evt
);

  logic signed [BITS_AB-1:0]   a_s;
  logic signed [BITS_AB-1:0]   b_s;
  logic signed [2*BITS_AB-1:0] prod;
  logic [BITS_C-1:0]           base;
  logic [SAT_W-1:0]            base_x;
  logic [SAT_W-1:0]            prod_x;
  logic [SAT_W:0]              res;
  logic                        fire;
  logic                        unused_hi;

  assign a_s    = a;
  assign b_s    = b;
  assign prod   = a_s * b_s;
  assign fire   = en & mac_en & a_valid & b_valid;
  // clr folds into the add so a same-cycle fire lands its bare product
  assign base   = clr ? '0 : acc;
  assign base_x = {{(SAT_W-BITS_C){base[BITS_C-1]}}, base};
  assign prod_x = {{(SAT_W-2*BITS_AB){prod[2*BITS_AB-1]}}, prod};
  assign res    = sat_add(base_x, prod_x, BITS_C, SATURATE != 0);
  assign ovf_evt   = fire & res[SAT_W];
  assign unused_hi = ^res[SAT_W-1:BITS_C];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      a_valid_reg <= 1'b0;
      b_reg       <= '0;
      b_valid_reg <= 1'b0;
      acc         <= '0;
    end else if (en) begin
      a_reg       <= a;
      a_valid_reg <= a_valid;
      b_reg       <= b;
      b_valid_reg <= b_valid;
      if (shift)
        acc <= shift_in;
      else if (fire)
        acc <= res[BITS_C-1:0];
      else if (mac_en && clr)
        acc <= '0;
    end
  end

endmodule

// File: rtl/tpumac_row.sv
// rtl/tpumac_row.sv - systolic row of N MAC PEs with load/drain accumulator shift chain
import tpu_pkg::*;

module tpumac_row #(
  parameter int N        = 4,
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [BITS_AB-1:0]   a_in,
  input  logic                 a_valid_in,
  output logic [BITS_AB-1:0]   a_out,
  output logic                 a_valid_out,
  input  logic [N*BITS_AB-1:0] b_in,
  input  logic [N-1:0]         b_valid_in,
  output logic [N*BITS_AB-1:0] b_out,
  output logic [N-1:0]         b_valid_out,
  input  logic                 clr,
  input  logic                 load_start,
  input  logic [BITS_C-1:0]    c_in,
  input  logic                 drain_start,
  output logic [BITS_C-1:0]    c_out,
  output logic                 c_out_valid,
  output logic                 drain_done,
  output logic                 busy,
  output logic                 ovf
);

  localparam int CW = $clog2(N);

  logic [N:0][BITS_AB-1:0] a_pe;
  logic [N:0]              a_v;
  logic [N:0][BITS_C-1:0]  acc_chain;
  logic [N-1:0]            ovf_vec;
  state_e                  state;
  logic [CW-1:0]           cnt;
  logic                    start;
  logic                    mac_en;
  logic                    shift;
  logic                    last;

  // A start cycle is still IDLE but must neither accumulate nor shift
  assign start  = (state == IDLE) && (load_start || drain_start);
  assign mac_en = (state == IDLE) && !start;
  assign shift  = (state != IDLE);
  assign last   = (cnt == CW'(N - 1));
  assign busy   = (state != IDLE);

  assign a_pe[0]      = a_in;
  assign a_v[0]       = a_valid_in;
  assign a_out        = a_pe[N];
  assign a_valid_out  = a_v[N];
  assign acc_chain[0] = (state == LOAD) ? c_in : '0;

  for (genvar j = 0; j < N; j++) begin : g_pe
    tpumac_pe #(
      .BITS_AB (BITS_AB),
      .BITS_C  (BITS_C),
      .SATURATE(SATURATE)
    ) u_pe (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .a          (a_pe[j]),
      .a_valid    (a_v[j]),
      .b          (b_in[j*BITS_AB +: BITS_AB]),
      .b_valid    (b_valid_in[j]),
      .mac_en     (mac_en),
      .clr        (clr),
      .shift      (shift),
      .shift_in   (acc_chain[j]),
      .a_reg      (a_pe[j+1]),
      .a_valid_reg(a_v[j+1]),
      .b_reg      (b_out[j*BITS_AB +: BITS_AB]),
      .b_valid_reg(b_valid_out[j]),
      .acc        (acc_chain[j+1]),
      .ovf_evt    (ovf_vec[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      c_out       <= '0;
      c_out_valid <= 1'b0;
      drain_done  <= 1'b0;
      ovf         <= 1'b0;
    end else if (en) begin
      c_out_valid <= 1'b0;
      drain_done  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (drain_start)
            state <= DRAIN;
          else if (load_start)
            state <= LOAD;
          if (mac_en) begin
            if (clr)
              ovf <= |ovf_vec;
            else if (|ovf_vec)
              ovf <= 1'b1;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          c_out       <= acc_chain[N];
          c_out_valid <= 1'b1;
          drain_done  <= last;
          cnt         <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpumac_row.sv
// tb/tb_tpumac_row.sv - self-checking bench for tpumac_row, saturating and wrapping instances
module tb_tpumac_row;

  localparam int N  = 4;
  localparam int BA = 8;
  localparam int BC = 16;

  logic            clk = 1'b0;
  logic            rst_n, en, a_valid_in, clr, load_start, drain_start;
  logic [BA-1:0]   a_in;
  logic [N*BA-1:0] b_in;
  logic [N-1:0]    b_valid_in;
  logic [BC-1:0]   c_in;

  logic [BA-1:0]   a_out, a_out_w;
  logic            a_valid_out, a_valid_out_w;
  logic [N*BA-1:0] b_out, b_out_w;
  logic [N-1:0]    b_valid_out, b_valid_out_w;
  logic [BC-1:0]   c_out, c_out_w;
  logic            c_out_valid, c_out_valid_w, drain_done, drain_done_w;
  logic            busy, busy_w, ovf, ovf_w;

  int errors = 0;
  int checks = 0;
  int q1[$];
  int q0[$];

  typedef struct {
    int pre;
    int a;
    int b;
    int e_sat;
    int e_wrap;
    bit e_ovf;
  } vec_t;
  vec_t vt[6];

  tpumac_row #(.N(N), .BITS_AB(BA), .BITS_C(BC), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .a_valid_in(a_valid_in),
    .a_out(a_out), .a_valid_out(a_valid_out), .b_in(b_in), .b_valid_in(b_valid_in),
    .b_out(b_out), .b_valid_out(b_valid_out), .clr(clr), .load_start(load_start),
    .c_in(c_in), .drain_start(drain_start), .c_out(c_out), .c_out_valid(c_out_valid),
    .drain_done(drain_done), .busy(busy), .ovf(ovf)
  );

  tpumac_row #(.N(N), .BITS_AB(BA), .BITS_C(BC), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .a_valid_in(a_valid_in),
    .a_out(a_out_w), .a_valid_out(a_valid_out_w), .b_in(b_in), .b_valid_in(b_valid_in),
    .b_out(b_out_w), .b_valid_out(b_valid_out_w), .clr(clr), .load_start(load_start),
    .c_in(c_in), .drain_start(drain_start), .c_out(c_out_w), .c_out_valid(c_out_valid_w),
    .drain_done(drain_done_w), .busy(busy_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int w[4], input bit mac);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load busy", busy, 1);
    for (int k = 0; k < N; k++) begin
      c_in = BC'(w[k]);
      if (mac) begin
        a_in       = 8'd5;
        a_valid_in = 1'b1;
        b_in       = {N{8'd5}};
        b_valid_in = '1;
      end
      step();
    end
    a_valid_in = 1'b0;
    b_valid_in = '0;
    chk("load end busy", busy, 0);
  endtask

  task automatic drain(input string nm, input int e1[4], input int e0[4],
                       input int stall_after, input bit ld);
    int              got1;
    int              v;
    bit              stalled;
    logic [N*BA-1:0] hold_b;
    logic [BA-1:0]   hold_a;
    got1    = 0;
    stalled = 1'b0;
    for (int k = 0; k < N; k++) begin
      q1.push_back(e1[k]);
      q0.push_back(e0[k]);
    end
    drain_start = 1'b1;
    load_start  = ld;
    step();
    drain_start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    for (int cyc = 0; cyc < 20 && (q1.size() > 0 || q0.size() > 0); cyc++) begin
      step();
      if (c_out_valid && q1.size() > 0) begin
        v = $signed(c_out);
        chk({nm, " word"}, v, q1.pop_front());
        chk({nm, " done"}, drain_done, int'(q1.size() == 0));
        got1++;
      end
      if (c_out_valid_w && q0.size() > 0) begin
        v = $signed(c_out_w);
        chk({nm, " word_w"}, v, q0.pop_front());
        chk({nm, " done_w"}, drain_done_w, int'(q0.size() == 0));
      end
      if (!stalled && stall_after > 0 && got1 == stall_after) begin
        stalled    = 1'b1;
        en         = 1'b0;
        a_in       = 8'd77;
        a_valid_in = 1'b1;
        b_in       = $urandom;
        b_valid_in = '1;
        hold_b     = b_out;
        hold_a     = a_out;
        for (int s = 0; s < 2; s++) begin
          step();
          v = $signed(c_out);
          chk("stall c_out", v, e1[stall_after-1]);
          chk("stall busy", busy, 1);
          chk("stall valid", c_out_valid, 1);
          chk("stall b_out", int'(b_out), int'(hold_b));
          chk("stall a_out", int'(a_out), int'(hold_a));
        end
        en         = 1'b1;
        a_valid_in = 1'b0;
        b_valid_in = '0;
      end
    end
    load_start = 1'b0;
    if (q1.size() > 0 || q0.size() > 0) begin
      chk({nm, " timeout"}, q1.size() + q0.size(), 0);
      q1.delete();
      q0.delete();
    end
    step();
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle valid"}, c_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int z[4];
    int w[4];
    int e[4];
    int f[4];
    vt[0] = '{pre: 0,      a: 3,    b: -5,   e_sat: -15,    e_wrap: -15,    e_ovf: 1'b0};
    vt[1] = '{pre: 32760,  a: 127,  b: 127,  e_sat: 32767,  e_wrap: -16647, e_ovf: 1'b1};
    vt[2] = '{pre: -32768, a: -128, b: 127,  e_sat: -32768, e_wrap: 16512,  e_ovf: 1'b1};
    vt[3] = '{pre: 100,    a: -128, b: -128, e_sat: 16484,  e_wrap: 16484,  e_ovf: 1'b0};
    vt[4] = '{pre: 32640,  a: 127,  b: 1,    e_sat: 32767,  e_wrap: 32767,  e_ovf: 1'b0};
    vt[5] = '{pre: -1,     a: 1,    b: 1,    e_sat: 0,      e_wrap: 0,      e_ovf: 1'b0};
    z = '{0, 0, 0, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = $urandom; a_valid_in = 1'b1; b_in = $urandom; b_valid_in = '1;
      clr = $urandom; load_start = 1'b1; drain_start = 1'b1; c_in = $urandom;
      step();
    end
    chk("rst a_out", int'(a_out), 0);
    chk("rst a_valid_out", a_valid_out, 0);
    chk("rst b_out", int'(b_out), 0);
    chk("rst b_valid_out", int'(b_valid_out), 0);
    chk("rst c_out", int'(c_out), 0);
    chk("rst c_out_valid", c_out_valid, 0);
    chk("rst drain_done", drain_done, 0);
    chk("rst busy", busy, 0);
    chk("rst ovf", ovf, 0);
    a_valid_in = 1'b0; b_valid_in = '0; clr = 1'b0;
    load_start = 1'b0; drain_start = 1'b0; c_in = '0; a_in = '0; b_in = '0;
    rst_n = 1'b1;
    step();

    w = '{10, 20, 30, 40};
    load(w, 1'b0);
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", c_out_valid, 0);
    chk("async rst busy", busy, 0);
    #1 rst_n = 1'b1;
    drain("post reset", z, z, -1, 1'b0);

    clr = 1'b1; a_in = 8'd3; a_valid_in = 1'b1;
    b_in = '0; b_in[0 +: BA] = 8'hFB; b_valid_in = 4'b0001;
    step();
    chk("b_out col0", int'(b_out[0 +: BA]), 251);
    chk("b_valid_out", int'(b_valid_out), 1);
    clr = 1'b0; a_valid_in = 1'b0;
    b_in[BA +: BA] = 8'd2; b_valid_in = 4'b0010;
    step();
    b_valid_in = '0;
    step();
    chk("a_valid_out early", a_valid_out, 0);
    step();
    chk("a_out", int'(a_out), 3);
    chk("a_valid_out", a_valid_out, 1);
    e = '{0, 0, 6, -15};
    drain("mac", e, e, -1, 1'b0);

    load(w, 1'b0);
    drain("load order", w, w, -1, 1'b0);
    drain("empty", z, z, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr ovf", ovf, 0);
      chk("clr ovf_w", ovf_w, 0);
      f = '{0, 0, 0, vt[i].pre};
      load(f, 1'b0);
      a_in = BA'(vt[i].a); a_valid_in = 1'b1;
      b_in = '0; b_in[0 +: BA] = BA'(vt[i].b); b_valid_in = 4'b0001;
      step();
      a_valid_in = 1'b0; b_valid_in = '0;
      chk("vec ovf", ovf, int'(vt[i].e_ovf));
      chk("vec ovf_w", ovf_w, int'(vt[i].e_ovf));
      e = '{0, 0, 0, vt[i].e_sat};
      f = '{0, 0, 0, vt[i].e_wrap};
      drain("vec", e, f, -1, 1'b0);
    end

    load(w, 1'b0);
    drain("stall", w, w, 2, 1'b0);

    w = '{1, 2, 3, 4};
    load(w, 1'b0);
    drain("both starts", w, w, -1, 1'b1);
    drain("load ignored", z, z, -1, 1'b0);
    w = '{7, 8, 9, 10};
    load(w, 1'b1);
    drain("mac in load", w, w, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
